// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the iterative FFT sequencer.
// Holds the state encoding, the ARRANGE phase-length rule and the default write-enable masks.
// Pure declarations: no logic, no latency, no backpressure.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREPARE = 3'd1,
        ST_CORE    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_ARRANGE = 3'd4
    } seq_state_t;

    localparam logic [5:0] DEF_WE_MASK_A = 6'b011011;
    localparam logic [5:0] DEF_WE_MASK_B = 6'b100100;

    // ARRANGE runs two cycles longer than PREPARE. The extra bit keeps an
    // all-ones point count from wrapping back to a short phase.
    function automatic logic [32:0] arrange_len(input logic [31:0] pts);
        return {1'b0, pts} + 33'd2;
    endfunction

endpackage

// File: rtl/fft_seq_phase_cnt.sv
// Phase counter for the FFT sequencer: counts cycles spent in the current phase.
// Latency: terminal flag is combinational from the registered count.
// Backpressure: none; clears whenever the sequencer changes state or is idle.
//
// Ports: clk, rst (sync, active-high), clear (state change), run (sequencer busy),
//        len (current phase length minus 1), cnt (cycles in phase), last (cnt == len).
module fft_seq_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == len);

endmodule

// File: rtl/fft_seq_ctrl.sv
// Iterative FFT sequencer: PREPARE, then CORE/WAIT/ARRANGE per stage, then IDLE.
// Latency: phase enables decode from the state register; we lags state by 1 cycle; done fires DONE_DELAY after the final ARRANGE cycle.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next edge.
//
// Ports: start/abort control, cfg_* (latched on start), busy, ena_* phase enables,
//        stage_level, we (registered write enables), done (1-cycle pulse).
// Optional: define FFT_SEQ_CTRL_PERF_EN to add perf_cycles, the busy-cycle count of
//           the last completed run (saturating, updated on its done pulse).
module fft_seq_ctrl
    import fft_seq_pkg::*;
#(
    parameter int                ADDR_WIDTH  = 12,
    parameter int                CORE_WIDTH  = 16,
    parameter int                WAIT_WIDTH  = 4,
    parameter int                STAGE_WIDTH = 4,
    parameter int                NUM_WE      = 6,
    parameter logic [NUM_WE-1:0] WE_MASK_A   = DEF_WE_MASK_A,
    parameter logic [NUM_WE-1:0] WE_MASK_B   = DEF_WE_MASK_B,
    parameter int                DONE_DELAY  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  cfg_pts,
    input  logic [CORE_WIDTH-1:0]  cfg_core,
    input  logic [WAIT_WIDTH-1:0]  cfg_wait,
    input  logic [STAGE_WIDTH-1:0] cfg_stages,
    output logic                   busy,
    output logic                   ena_prepare,
    output logic                   ena_fft_core,
    output logic                   ena_fft_wait,
    output logic                   ena_arrange,
    output logic [STAGE_WIDTH-1:0] stage_level,
    output logic [NUM_WE-1:0]      we,
    output logic                   done
`ifdef FFT_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam int CNT_W = (ADDR_WIDTH + 1 > CORE_WIDTH) ? ADDR_WIDTH + 1 : CORE_WIDTH;

    seq_state_t             state, state_nxt;
    logic [STAGE_WIDTH-1:0] stage_nxt;
    logic [ADDR_WIDTH-1:0]  pts_q;
    logic [CORE_WIDTH-1:0]  core_q;
    logic [WAIT_WIDTH-1:0]  wait_q;
    logic [STAGE_WIDTH-1:0] stages_q;
    logic [STAGE_WIDTH-1:0] stages_eff;
    logic [CNT_W-1:0]       phase_len;
    logic [CNT_W-1:0]       phase_cnt;
    logic                   phase_last;
    logic                   accept;
    logic                   fin;
    logic [DONE_DELAY-1:0]  done_pipe;

    assign stages_eff = (stages_q == '0) ? STAGE_WIDTH'(1) : stages_q;

    always_comb begin
        phase_len = '0;
        case (state)
            ST_PREPARE: phase_len = CNT_W'(pts_q);
            ST_CORE:    phase_len = CNT_W'(core_q);
            ST_WAIT:    phase_len = CNT_W'(wait_q);
            ST_ARRANGE: phase_len = CNT_W'(arrange_len(32'(pts_q)));
            default:    phase_len = '0;
        endcase
    end

    fft_seq_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state_nxt != state),
        .run   (busy),
        .len   (phase_len),
        .cnt   (phase_cnt),
        .last  (phase_last)
    );

    // Next state, stage index and the phase decode all come from the registered state.
    always_comb begin
        state_nxt    = state;
        stage_nxt    = stage_level;
        accept       = 1'b0;
        fin          = 1'b0;
        busy         = (state != ST_IDLE);
        ena_prepare  = (state == ST_PREPARE);
        ena_fft_core = (state == ST_CORE);
        ena_fft_wait = (state == ST_WAIT);
        ena_arrange  = (state == ST_ARRANGE);
        if (abort) begin
            state_nxt = ST_IDLE;
            stage_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_PREPARE;
                    stage_nxt = '0;
                end
                ST_PREPARE: if (phase_last) state_nxt = ST_CORE;
                ST_CORE:    if (phase_last) state_nxt = ST_WAIT;
                ST_WAIT:    if (phase_last) state_nxt = ST_ARRANGE;
                ST_ARRANGE: if (phase_last) begin
                    if (stage_level == stages_eff - 1'b1) begin
                        state_nxt = ST_IDLE;
                        stage_nxt = '0;
                        fin       = 1'b1;
                    end else begin
                        state_nxt = ST_CORE;
                        stage_nxt = stage_level + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    stage_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            stage_level <= '0;
            pts_q       <= '0;
            core_q      <= '0;
            wait_q      <= '0;
            stages_q    <= '0;
            we          <= '0;
            done_pipe   <= '0;
        end else begin
            state       <= state_nxt;
            stage_level <= stage_nxt;
            if (accept) begin
                pts_q    <= cfg_pts;
                core_q   <= cfg_core;
                wait_q   <= cfg_wait;
                stages_q <= cfg_stages;
            end
            case (state)
                ST_PREPARE, ST_ARRANGE: we <= WE_MASK_A;
                ST_CORE, ST_WAIT:       we <= WE_MASK_B;
                default:                we <= '0;
            endcase
            // A pending done from the previous run keeps shifting through a new start;
            // only abort flushes it.
            if (abort) begin
                done_pipe <= '0;
            end else begin
                done_pipe <= (done_pipe << 1) | DONE_DELAY'(fin);
            end
        end
    end

    assign done = done_pipe[DONE_DELAY-1];

`ifdef FFT_SEQ_CTRL_PERF_EN
    logic [31:0] run_cnt;
    logic [31:0] perf_pend;

    // run_cnt counts busy cycles before the current one, so the finishing
    // cycle is added when the result is parked until its done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt     <= '0;
            perf_pend   <= '0;
            perf_cycles <= '0;
        end else begin
            if (accept) begin
                run_cnt <= '0;
            end else if (busy && run_cnt != '1) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (fin) begin
                perf_pend <= (run_cnt == '1) ? '1 : run_cnt + 1'b1;
            end
            if (done) begin
                perf_cycles <= perf_pend;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Testbench for fft_seq_ctrl: directed runs with a per-cycle expected trace and
// an expected done-cycle queue, checked by a monitor on the falling edge.
module tb_fft_seq_ctrl;

    localparam int DD = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [11:0] cfg_pts;
    logic [15:0] cfg_core;
    logic [3:0]  cfg_wait;
    logic [3:0]  cfg_stages;
    logic        busy;
    logic        ena_prepare, ena_fft_core, ena_fft_wait, ena_arrange;
    logic [3:0]  stage_level;
    logic [5:0]  we;
    logic        done;
`ifdef FFT_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    fft_seq_ctrl #(
        .ADDR_WIDTH(12), .CORE_WIDTH(16), .WAIT_WIDTH(4), .STAGE_WIDTH(4),
        .NUM_WE(6), .WE_MASK_A(6'b011011), .WE_MASK_B(6'b100100), .DONE_DELAY(DD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_pts      (cfg_pts),
        .cfg_core     (cfg_core),
        .cfg_wait     (cfg_wait),
        .cfg_stages   (cfg_stages),
        .busy         (busy),
        .ena_prepare  (ena_prepare),
        .ena_fft_core (ena_fft_core),
        .ena_fft_wait (ena_fft_wait),
        .ena_arrange  (ena_arrange),
        .stage_level  (stage_level),
        .we           (we),
        .done         (done)
`ifdef FFT_SEQ_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    typedef struct packed {
        logic       busy;
        logic [3:0] ena;   // {prepare, core, wait, arrange}
        logic [3:0] stg;
        logic [5:0] we;
    } obs_t;

    obs_t exp_q[$];
    int   done_q[$];
    int   perf_q[$];
    int   ncyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // State codes: 0 idle, 1 prepare, 2 core, 3 wait, 4 arrange.
    // prev is the state of the preceding cycle, which sets we.
    function automatic obs_t mk(input int st, input int stg, input int prev);
        obs_t o;
        o.busy = (st != 0);
        o.ena  = (st == 1) ? 4'b1000 : (st == 2) ? 4'b0100 :
                 (st == 3) ? 4'b0010 : (st == 4) ? 4'b0001 : 4'b0000;
        o.stg  = 4'(stg);
        o.we   = (prev == 1 || prev == 4) ? 6'b011011 :
                 (prev == 2 || prev == 3) ? 6'b100100 : 6'b000000;
        return o;
    endfunction

`ifdef FFT_SEQ_CTRL_PERF_EN
    bit perf_chk = 1'b0;
    int perf_exp = 0;
`endif

    // Monitor: one trace entry per cycle while a run is expected, plus every done pulse.
    always @(negedge clk) begin
        obs_t e, a;
        int   d;
        ncyc++;
`ifdef FFT_SEQ_CTRL_PERF_EN
        if (perf_chk) begin
            perf_chk = 1'b0;
            n_cmp++;
            if (perf_cycles != 32'(perf_exp)) begin
                n_err++;
                $display("FAIL perf_cycles cyc=%0d got %0d want %0d", ncyc, perf_cycles, perf_exp);
            end
        end
`endif
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {busy, ena_prepare, ena_fft_core, ena_fft_wait, ena_arrange, stage_level, we};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL trace cyc=%0d got busy=%b ena=%b stg=%0d we=%b want busy=%b ena=%b stg=%0d we=%b",
                         ncyc, a.busy, a.ena, a.stg, a.we, e.busy, e.ena, e.stg, e.we);
            end
        end
        if (done === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected cyc=%0d got done=1 want done=0", ncyc);
            end else begin
                d = done_q.pop_front();
                if (d != ncyc) begin
                    n_err++;
                    $display("FAIL done_cycle got %0d want %0d", ncyc, d);
                end
`ifdef FFT_SEQ_CTRL_PERF_EN
                perf_exp = perf_q.pop_front();
                perf_chk = 1'b1;
`endif
            end
        end
    end

    // kind: 0 normal, 1 abort during busy cycle cut, 2 rst during busy cycle cut.
    // noise: pulse start and scramble cfg_pts every busy cycle.
    task automatic run(input int pts, input int core, input int wt, input int stg,
                       input int cut, input int kind, input bit noise);
        int sq[$];
        int sg[$];
        int ns, nb;
        ns = (stg == 0) ? 1 : stg;
        for (int i = 0; i <= pts; i++) begin sq.push_back(1); sg.push_back(0); end
        for (int s = 0; s < ns; s++) begin
            for (int i = 0; i <= core; i++)    begin sq.push_back(2); sg.push_back(s); end
            for (int i = 0; i <= wt; i++)      begin sq.push_back(3); sg.push_back(s); end
            for (int i = 0; i <= pts + 2; i++) begin sq.push_back(4); sg.push_back(s); end
        end
        nb = (cut < 0) ? sq.size() : cut + 1;
        @(posedge clk); #1;
        cfg_pts    = 12'(pts);
        cfg_core   = 16'(core);
        cfg_wait   = 4'(wt);
        cfg_stages = 4'(stg);
        start      = 1'b1;
        exp_q.push_back(mk(0, 0, 0));
        for (int i = 0; i < nb; i++) exp_q.push_back(mk(sq[i], sg[i], (i == 0) ? 0 : sq[i-1]));
        exp_q.push_back(mk(0, 0, (kind == 2) ? 0 : sq[nb-1]));
        exp_q.push_back(mk(0, 0, 0));
        if (cut < 0) begin
            done_q.push_back(ncyc + 1 + nb + DD);
            perf_q.push_back(nb);
        end
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            start = noise;
            if (noise) cfg_pts = 12'($urandom);
            abort = (i == cut) && (kind == 1);
            rst   = (i == cut) && (kind == 2);
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_pts = '0; cfg_core = '0; cfg_wait = '0; cfg_stages = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);

        // Two-stage run: 4 + 2*(6+3+6) = 34 busy cycles.
        run(3, 5, 2, 2, -1, 0, 1'b0);
        idle(12);
        // Zero stages behaves as one: 1+1+1+3 = 6 busy cycles; next start while done in flight.
        run(0, 0, 0, 0, -1, 0, 1'b0);
        run(3, 5, 2, 2, -1, 0, 1'b0);
        idle(12);
        // Abort on the third cycle of the second CORE phase (busy cycle 21).
        run(3, 5, 2, 2, 21, 1, 1'b0);
        // Following run with start pulsed every cycle and cfg_pts changing mid-run.
        run(1, 2, 1, 3, -1, 0, 1'b1);
        idle(14);
        // start together with abort in IDLE: no run begins.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        repeat (3) exp_q.push_back(mk(0, 0, 0));
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        // Reset in the middle of the first ARRANGE phase (busy cycles 13..18).
        run(3, 5, 2, 2, 15, 2, 1'b0);
`ifdef FFT_SEQ_CTRL_PERF_EN
        n_cmp++;
        if (perf_cycles != 32'd0) begin
            n_err++;
            $display("FAIL perf_after_rst got %0d want 0", perf_cycles);
        end
`endif
        run(2, 1, 0, 3, -1, 0, 1'b0);
        idle(14);

        n_cmp++;
        if (done_q.size() != 0) begin
            n_err++;
            $display("FAIL done_missing got %0d pending want 0", done_q.size());
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL trace_left got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
